// File: rtl/async_wr_addr_cac.sv
// Write-side pointer, full/almost-full and fill-level logic of a dual-clock FIFO.
// Everything here runs in the wr_clk domain; rd_addr_gray arrives unsynchronised.
module async_wr_addr_cac #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE:0]   rd_addr_gray,
  input  logic                 ovf_clr,
  output logic [ADDR_SIZE:0]   wr_addr_gray,
  output logic [ADDR_SIZE-1:0] wr_addr,
  output logic                 ram_we,
  output logic                 full,
  output logic                 almost_full,
  output logic [ADDR_SIZE:0]   wr_level,
  output logic                 overflow
);

  localparam logic [ADDR_SIZE:0] AFULL_LVL = (ADDR_SIZE+1)'(AFULL_THRESH);

  logic [ADDR_SIZE:0] sync1_q, sync2_q;
  logic [ADDR_SIZE:0] bin_q, bin_d;
  logic [ADDR_SIZE:0] gray_q, gray_d;
  logic [ADDR_SIZE:0] level_q, level_d;
  logic               full_q, full_d;
  logic               afull_q, afull_d;
  logic               ovf_q, ovf_d;
  logic [ADDR_SIZE:0] rd_bin;
  logic               wr_vld;

  always_comb begin
    wr_vld = wr_en & ~full_q & ~wr_rst;
    bin_d  = bin_q + {{ADDR_SIZE{1'b0}}, wr_vld};
    gray_d = (bin_d >> 1) ^ bin_d;

    rd_bin[ADDR_SIZE] = sync2_q[ADDR_SIZE];
    for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
      rd_bin[i] = rd_bin[i+1] ^ sync2_q[i];
    end

    // Full when the write pointer has lapped the read pointer by exactly one depth.
    full_d  = (gray_d == {~sync2_q[ADDR_SIZE:ADDR_SIZE-1], sync2_q[ADDR_SIZE-2:0]});
    level_d = bin_d - rd_bin;
    afull_d = (level_d >= AFULL_LVL);

    ovf_d = ovf_q;
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      bin_q   <= '0;
      gray_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= rd_addr_gray;
      sync2_q <= sync1_q;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign wr_addr_gray = gray_q;
  assign wr_addr      = bin_q[ADDR_SIZE-1:0];
  assign ram_we       = wr_vld;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign wr_level     = level_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_async_wr_addr_cac.sv
// Self-checking bench for async_wr_addr_cac: directed vectors, a count-based
// reference model checked every cycle, and hand-computed literal checkpoints.
module tb_async_wr_addr_cac;

  logic       wr_clk = 1'b0;
  logic       wr_rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] rd_bin_tb = '0;
  logic [4:0] rd_addr_gray;
  logic       ovf_clr = 1'b0;
  logic [4:0] wr_addr_gray;
  logic [3:0] wr_addr;
  logic       ram_we;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model state: plain integer counts of writes and delayed read pointer
  int m_ptr = 0, m_level = 0, h1 = 0, h2 = 0;
  bit m_full = 0, m_afull = 0, m_ovf = 0;

  assign rd_addr_gray = rd_bin_tb ^ (rd_bin_tb >> 1);

  async_wr_addr_cac #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .rd_addr_gray(rd_addr_gray),
    .ovf_clr(ovf_clr), .wr_addr_gray(wr_addr_gray), .wr_addr(wr_addr),
    .ram_we(ram_we), .full(full), .almost_full(almost_full),
    .wr_level(wr_level), .overflow(overflow)
  );

  always #5 wr_clk = ~wr_clk;

  // The model sees the read pointer two edges late; occupancy is writes minus that.
  always @(posedge wr_clk) begin
    if (wr_rst) begin
      m_ptr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; h1 = 0; h2 = 0;
    end else begin
      if (wr_en && m_full) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (wr_en && !m_full) m_ptr = (m_ptr + 1) % 32;
      m_level = (m_ptr - h2 + 32) % 32;
      m_full  = (m_level == 16);
      m_afull = (m_level >= 12);
      h2 = h1;
      h1 = int'(rd_bin_tb);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit we, input int rd, input bit clr, input bit rst);
    @(negedge wr_clk);
    #1;
    wr_en = we;
    rd_bin_tb = 5'(rd);
    ovf_clr = clr;
    wr_rst = rst;
    #2;
  endtask

  always begin
    @(negedge wr_clk);
    #3;
    if (chk_en) begin
      checkOutput("mdl_level", int'(wr_level), m_level);
      checkOutput("mdl_full", int'(full), int'(m_full));
      checkOutput("mdl_afull", int'(almost_full), int'(m_afull));
      checkOutput("mdl_ovf", int'(overflow), int'(m_ovf));
      checkOutput("mdl_gray", int'(wr_addr_gray), m_ptr ^ (m_ptr >> 1));
      checkOutput("mdl_addr", int'(wr_addr), m_ptr % 16);
      checkOutput("mdl_we", int'(ram_we), int'(wr_en && !m_full && !wr_rst));
    end
  end

  initial begin
    int wcount;
    int maxlvl;
    bit full_seen;

    // Reset held two cycles with writes requested
    applyStimulus(1, 0, 0, 1);
    checkOutput("t1_we_rst0", int'(ram_we), 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t1_we_rst1", int'(ram_we), 0);
    checkOutput("t1_gray", int'(wr_addr_gray), 0);
    checkOutput("t1_level", int'(wr_level), 0);
    checkOutput("t1_full", int'(full), 0);
    checkOutput("t1_afull", int'(almost_full), 0);
    checkOutput("t1_ovf", int'(overflow), 0);
    chk_en = 1'b1;

    // Sixteen back-to-back writes fill the FIFO
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("t2_addr", int'(wr_addr), i);
      checkOutput("t2_we", int'(ram_we), 1);
      if (i == 11) checkOutput("t2_afull_11", int'(almost_full), 0);
      if (i == 12) checkOutput("t2_afull_12", int'(almost_full), 1);
    end

    // Writes refused while full, overflow latched then cleared
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0);
      checkOutput("t3_full", int'(full), 1);
      checkOutput("t3_gray", int'(wr_addr_gray), 24);
      checkOutput("t3_level", int'(wr_level), 16);
      checkOutput("t3_we", int'(ram_we), 0);
    end
    applyStimulus(0, 0, 1, 0);
    checkOutput("t3_ovf_set", int'(overflow), 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t3_ovf_clr", int'(overflow), 0);

    // Read pointer moves to 4, then 5; effect lands three edges later
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 4, 0, 0);
      if (k < 3) checkOutput("t4_full_hold", int'(full), 1);
    end
    checkOutput("t4_full_drop", int'(full), 0);
    checkOutput("t4_level12", int'(wr_level), 12);
    checkOutput("t4_afull12", int'(almost_full), 1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 5, 0, 0);
    checkOutput("t4_level11", int'(wr_level), 11);
    checkOutput("t4_afull11", int'(almost_full), 0);

    // Forty writes with the reader close behind, crossing the pointer wrap
    for (int k = 0; k < 3; k++) applyStimulus(0, 15, 0, 0);
    wcount = 16;
    maxlvl = 0;
    full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, (wcount - 1) % 32, 0, 0);
      if (wcount == 31) checkOutput("t5_gray_31", int'(wr_addr_gray), 16);
      if (wcount == 32) checkOutput("t5_gray_wrap", int'(wr_addr_gray), 0);
      if (int'(wr_level) > maxlvl) maxlvl = int'(wr_level);
      if (full) full_seen = 1;
      wcount++;
    end
    checkOutput("t5_level_le4", int'(maxlvl <= 4), 1);
    checkOutput("t5_never_full", int'(full_seen), 0);

    // Reset mid-burst at level 7
    for (int k = 0; k < 3; k++) applyStimulus(0, 22, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(1, 22, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t6_level7", int'(wr_level), 7);
    checkOutput("t6_we_rst", int'(ram_we), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t6_gray", int'(wr_addr_gray), 0);
    checkOutput("t6_level", int'(wr_level), 0);
    checkOutput("t6_full", int'(full), 0);
    checkOutput("t6_ovf", int'(overflow), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
